// File: rtl/i2q2_compute_pkg.sv
// Shared widths, limits and FSM state encoding for the I^2+Q^2 correlator
// power block and its squarer.
package i2q2_compute_pkg;

  localparam int ACC_WIDTH_DEF    = 16;
  localparam int MULT_LATENCY_MIN = 1;
  localparam int MULT_LATENCY_MAX = 4;
  localparam int NUM_OPERANDS     = 6;
  localparam int NUM_CORR         = 3;
  localparam int TAG_WIDTH        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int i2q2_width(input int acc_width);
    return 2 * acc_width;
  endfunction

endpackage

// File: rtl/i2q2_compute_square_pipe.sv
// Pipelined squarer of a signed operand; a valid bit and correlator tag
// travel alongside the data so results can be routed on arrival.
module square_pipe
  import i2q2_compute_pkg::*;
#(
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int MULT_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     global_reset,
  input  logic [ACC_WIDTH-1:0]     din,
  input  logic                     din_valid,
  input  logic [TAG_WIDTH-1:0]     din_tag,
  output logic [2*ACC_WIDTH-1:0]   dout,
  output logic                     dout_valid,
  output logic [TAG_WIDTH-1:0]     dout_tag
);

  localparam int OW = i2q2_width(ACC_WIDTH);

  logic [OW-1:0]        din_ext;
  logic [OW-1:0]        square;
  logic [OW-1:0]        stg_data  [MULT_LATENCY+1];
  logic                 stg_valid [MULT_LATENCY+1];
  logic [TAG_WIDTH-1:0] stg_tag   [MULT_LATENCY+1];

  // Sign-extend to full width; the low 2*W bits of the product are the exact
  // square since the largest square, 2^(2W-2), is well below 2^(2W).
  assign din_ext = {{ACC_WIDTH{din[ACC_WIDTH-1]}}, din};
  assign square  = din_ext * din_ext;

  assign stg_data[0]  = square;
  assign stg_valid[0] = din_valid;
  assign stg_tag[0]   = din_tag;

  for (genvar gi = 0; gi < MULT_LATENCY; gi++) begin : g_stage
    logic [OW-1:0]        data_reg;
    logic                 valid_reg;
    logic [TAG_WIDTH-1:0] tag_reg;

    always_ff @(posedge clk) begin
      if (global_reset) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
        tag_reg   <= '0;
      end else begin
        data_reg  <= stg_data[gi];
        valid_reg <= stg_valid[gi];
        tag_reg   <= stg_tag[gi];
      end
    end

    assign stg_data[gi+1]  = data_reg;
    assign stg_valid[gi+1] = valid_reg;
    assign stg_tag[gi+1]   = tag_reg;
  end

  assign dout       = stg_data[MULT_LATENCY];
  assign dout_valid = stg_valid[MULT_LATENCY];
  assign dout_tag   = stg_tag[MULT_LATENCY];

endmodule

// File: rtl/i2q2_compute.sv
// Computes I^2+Q^2 for early/prompt/late correlators through one shared
// pipelined squarer; results publish together with a one-cycle valid pulse.
module i2q2_compute
  import i2q2_compute_pkg::*;
#(
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int MULT_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   global_reset,
  input  logic                   accumulation_complete,
  input  logic [ACC_WIDTH-1:0]   i_early,
  input  logic [ACC_WIDTH-1:0]   q_early,
  input  logic [ACC_WIDTH-1:0]   i_prompt,
  input  logic [ACC_WIDTH-1:0]   q_prompt,
  input  logic [ACC_WIDTH-1:0]   i_late,
  input  logic [ACC_WIDTH-1:0]   q_late,
  output logic [2*ACC_WIDTH-1:0] i2q2_early,
  output logic [2*ACC_WIDTH-1:0] i2q2_prompt,
  output logic [2*ACC_WIDTH-1:0] i2q2_late,
  output logic                   i2q2_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int         OW         = i2q2_width(ACC_WIDTH);
  localparam logic [2:0] DRAIN_LAST = 3'(MULT_LATENCY);
  localparam logic [2:0] IDX_LAST   = 3'(NUM_OPERANDS - 1);

  state_t               state_reg, state_next;
  logic [2:0]           idx_reg;
  logic [2:0]           drain_cnt_reg;
  logic                 overrun_reg;
  logic                 accept;
  logic                 publish;

  logic [ACC_WIDTH-1:0] in_vec   [NUM_OPERANDS];
  logic [ACC_WIDTH-1:0] snap_vec [NUM_OPERANDS];
  logic [OW-1:0]        out_vec  [NUM_CORR];

  logic [ACC_WIDTH-1:0] sq_din;
  logic                 sq_valid;
  logic [TAG_WIDTH-1:0] sq_tag;
  logic [OW-1:0]        sq_dout;
  logic                 sq_dout_valid;
  logic [TAG_WIDTH-1:0] sq_dout_tag;

  assign accept  = (state_reg == ST_IDLE) && accumulation_complete;
  assign publish = (state_reg == ST_DRAIN) && (drain_cnt_reg == DRAIN_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accumulation_complete) state_next = ST_ISSUE;
      ST_ISSUE: if (idx_reg == IDX_LAST) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_reg == DRAIN_LAST) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      drain_cnt_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      overrun_reg   <= accumulation_complete && (state_reg != ST_IDLE);
      if (accept)
        idx_reg <= '0;
      else if (state_reg == ST_ISSUE)
        idx_reg <= idx_reg + 3'd1;
      drain_cnt_reg <= (state_reg == ST_DRAIN) ? drain_cnt_reg + 3'd1 : 3'd0;
    end
  end

  assign in_vec = '{i_early, q_early, i_prompt, q_prompt, i_late, q_late};

  for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_snap
    logic [ACC_WIDTH-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (global_reset)
        data_reg <= '0;
      else if (accept)
        data_reg <= in_vec[gi];
    end
    assign snap_vec[gi] = data_reg;
  end

  // Operand pairs (I,Q) share a correlator, so the tag is the index halved.
  assign sq_din   = snap_vec[idx_reg];
  assign sq_valid = (state_reg == ST_ISSUE);
  assign sq_tag   = idx_reg[2:1];

  square_pipe #(
    .ACC_WIDTH    (ACC_WIDTH),
    .MULT_LATENCY (MULT_LATENCY)
  ) u_square_pipe (
    .clk          (clk),
    .global_reset (global_reset),
    .din          (sq_din),
    .din_valid    (sq_valid),
    .din_tag      (sq_tag),
    .dout         (sq_dout),
    .dout_valid   (sq_dout_valid),
    .dout_tag     (sq_dout_tag)
  );

  for (genvar gi = 0; gi < NUM_CORR; gi++) begin : g_corr
    logic [OW-1:0] sum_reg;
    logic [OW-1:0] out_reg;
    always_ff @(posedge clk) begin
      if (global_reset) begin
        sum_reg <= '0;
        out_reg <= '0;
      end else begin
        if (accept)
          sum_reg <= '0;
        else if (sq_dout_valid && (sq_dout_tag == TAG_WIDTH'(gi)))
          sum_reg <= sum_reg + sq_dout;
        if (publish)
          out_reg <= sum_reg;
      end
    end
    assign out_vec[gi] = out_reg;
  end

  assign i2q2_early  = out_vec[0];
  assign i2q2_prompt = out_vec[1];
  assign i2q2_late   = out_vec[2];
  assign i2q2_valid  = (state_reg == ST_DONE);
  assign busy        = (state_reg != ST_IDLE);
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_i2q2_compute.sv
// Randomized self-checking bench for i2q2_compute against an arithmetic
// reference (I*I + Q*Q per correlator, fixed result cycle after the strobe).
module tb_i2q2_compute;

  localparam int W  = 16;
  localparam int L  = 2;
  localparam int OW = 2 * W;
  localparam int VC = 8 + L;

  logic          clk = 1'b0;
  logic          global_reset = 1'b1;
  logic          accumulation_complete = 1'b0;
  logic [W-1:0]  i_early = '0, q_early = '0, i_prompt = '0;
  logic [W-1:0]  q_prompt = '0, i_late = '0, q_late = '0;
  logic [OW-1:0] i2q2_early, i2q2_prompt, i2q2_late;
  logic          i2q2_valid, busy, overrun;

  i2q2_compute #(.ACC_WIDTH(W), .MULT_LATENCY(L)) dut (
    .clk                   (clk),
    .global_reset          (global_reset),
    .accumulation_complete (accumulation_complete),
    .i_early               (i_early),
    .q_early               (q_early),
    .i_prompt              (i_prompt),
    .q_prompt              (q_prompt),
    .i_late                (i_late),
    .q_late                (q_late),
    .i2q2_early            (i2q2_early),
    .i2q2_prompt           (i2q2_prompt),
    .i2q2_late             (i2q2_late),
    .i2q2_valid            (i2q2_valid),
    .busy                  (busy),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int     c;
    longint e;
    longint p;
    longint l;
  } vrec_t;

  vrec_t vq[$];
  int    oq[$];

  always @(negedge clk) begin
    vrec_t r;
    if (i2q2_valid === 1'b1) begin
      r.c = cyc; r.e = longint'(i2q2_early); r.p = longint'(i2q2_prompt); r.l = longint'(i2q2_late);
      vq.push_back(r);
    end
    if (overrun === 1'b1) oq.push_back(cyc);
  end

  function automatic longint mag(input int i, input int q);
    return longint'(i) * longint'(i) + longint'(q) * longint'(q);
  endfunction

  function automatic int rnd_val();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return -32768;
    if (sel == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic drive(input int d[6]);
    i_early  = d[0][W-1:0]; q_early  = d[1][W-1:0];
    i_prompt = d[2][W-1:0]; q_prompt = d[3][W-1:0];
    i_late   = d[4][W-1:0]; q_late   = d[5][W-1:0];
  endtask

  task automatic scramble();
    int d[6];
    for (int k = 0; k < 6; k++) d[k] = int'($urandom_range(0, 65535));
    drive(d);
  endtask

  // Strobe in cycle 0; returns at the middle of cycle 1 with inputs scrambled.
  task automatic start(input int d[6], output int c0);
    @(negedge clk);
    drive(d);
    accumulation_complete = 1'b1;
    c0 = cyc;
    @(negedge clk);
    accumulation_complete = 1'b0;
    scramble();
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    accumulation_complete = 1'b1;
    scramble();
    repeat (3) @(negedge clk);
    total++;
    if ({i2q2_early, i2q2_prompt, i2q2_late} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h %h %h, want 0", i2q2_early, i2q2_prompt, i2q2_late);
    end
    total++;
    if ({busy, i2q2_valid, overrun} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: busy/valid/overrun got %b%b%b, want 000", busy, i2q2_valid, overrun);
    end
    global_reset = 1'b0;
    accumulation_complete = 1'b0;
    vq.delete(); oq.delete();
    repeat (VC + 3) @(negedge clk);
    #1;
    total++;
    if (vq.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_strobe_discard: valid pulses %0d busy %b, want 0 0", vq.size(), busy);
    end
    $display("txn reset: outputs cleared, strobe under reset discarded");
  endtask

  task automatic test_basic();
    int d[6] = '{3, 4, -5, 12, 0, 0};
    int c0;
    int busy_err = 0;
    vq.delete(); oq.delete();
    start(d, c0);
    for (int k = 1; k <= VC + 3; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (busy !== (k <= VC)) busy_err++;
    end
    total++;
    if (busy_err != 0) begin
      bad++; $display("FAIL basic_busy: %0d cycles with wrong busy, want 0", busy_err);
    end
    total++;
    if (vq.size() != 1 || vq[0].c - c0 != VC) begin
      bad++; $display("FAIL basic_valid_timing: pulses %0d first at %0d, want 1 at %0d", vq.size(), (vq.size() > 0) ? vq[0].c - c0 : -1, VC);
    end
    total++;
    if (vq.size() < 1 || vq[0].e != mag(d[0], d[1]) || vq[0].p != mag(d[2], d[3]) || vq[0].l != mag(d[4], d[5])) begin
      bad++; $display("FAIL basic_values: got %0d %0d %0d, want %0d %0d %0d", i2q2_early, i2q2_prompt, i2q2_late, mag(d[0], d[1]), mag(d[2], d[3]), mag(d[4], d[5]));
    end
    repeat (6) begin @(negedge clk); scramble(); end
    #1;
    total++;
    if (longint'(i2q2_early) != 25 || longint'(i2q2_prompt) != 169 || longint'(i2q2_late) != 0) begin
      bad++; $display("FAIL basic_hold: got %0d %0d %0d, want 25 169 0", i2q2_early, i2q2_prompt, i2q2_late);
    end
    $display("txn basic: early=%0d prompt=%0d late=%0d", i2q2_early, i2q2_prompt, i2q2_late);
  endtask

  task automatic test_extreme();
    int d[6] = '{-32768, -32768, -32768, -32768, -32768, -32768};
    int c0;
    vq.delete(); oq.delete();
    start(d, c0);
    for (int k = 2; k <= VC + 1; k++) @(negedge clk);
    #1;
    total++;
    if (vq.size() != 1 || vq[0].c - c0 != VC || vq[0].e != mag(d[0], d[1]) || vq[0].p != mag(d[2], d[3]) || vq[0].l != mag(d[4], d[5])) begin
      bad++; $display("FAIL extreme: got %h %h %h pulses %0d, want %h each once", i2q2_early, i2q2_prompt, i2q2_late, vq.size(), mag(d[0], d[1]));
    end
    $display("txn extreme: early=%h prompt=%h late=%h", i2q2_early, i2q2_prompt, i2q2_late);
  endtask

  task automatic test_overrun();
    int d[6] = '{1, 0, 0, 0, 0, 0};
    int c0;
    vq.delete(); oq.delete();
    start(d, c0);
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      scramble();
      accumulation_complete = (k == 5);
      if (k == 5) i_early = W'(7);
    end
    #1;
    total++;
    if (oq.size() != 1 || oq[0] - c0 != 6) begin
      bad++; $display("FAIL overrun_pulse: pulses %0d first at %0d, want 1 at 6", oq.size(), (oq.size() > 0) ? oq[0] - c0 : -1);
    end
    total++;
    if (vq.size() != 1 || vq[0].c - c0 != VC || vq[0].e != 1 || vq[0].p != 0 || vq[0].l != 0) begin
      bad++; $display("FAIL overrun_result: pulses %0d early %0d, want 1 pulse early 1", vq.size(), i2q2_early);
    end
    $display("txn overrun: overrun pulses=%0d valid pulses=%0d early=%0d", oq.size(), vq.size(), i2q2_early);
  endtask

  task automatic test_abort();
    int d[6] = '{100, 200, 300, 400, 500, 600};
    int c0;
    vq.delete(); oq.delete();
    start(d, c0);
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      scramble();
      global_reset = (k == 4);
    end
    #1;
    total++;
    if (vq.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_no_valid: pulses %0d busy %b, want 0 0", vq.size(), busy);
    end
    total++;
    if ({i2q2_early, i2q2_prompt, i2q2_late} !== '0) begin
      bad++; $display("FAIL abort_outputs: got %0d %0d %0d, want 0 0 0", i2q2_early, i2q2_prompt, i2q2_late);
    end
    $display("txn abort: valid pulses=%0d outputs=%0d/%0d/%0d", vq.size(), i2q2_early, i2q2_prompt, i2q2_late);
  endtask

  task automatic test_back_to_back();
    int d1[6];
    int d2[6];
    int c0;
    for (int k = 0; k < 6; k++) begin d1[k] = rnd_val(); d2[k] = rnd_val(); end
    vq.delete(); oq.delete();
    start(d1, c0);
    for (int k = 2; k <= 2 * VC + 4; k++) begin
      @(negedge clk);
      if (k == VC + 1) drive(d2); else scramble();
      accumulation_complete = (k == VC + 1);
    end
    #1;
    total++;
    if (vq.size() != 2 || vq[0].c - c0 != VC || vq[1].c - c0 != 2 * VC + 1) begin
      bad++; $display("FAIL b2b_timing: pulses %0d, want 2 at %0d and %0d", vq.size(), VC, 2 * VC + 1);
    end
    total++;
    if (vq.size() < 1 || vq[0].e != mag(d1[0], d1[1]) || vq[0].p != mag(d1[2], d1[3]) || vq[0].l != mag(d1[4], d1[5])) begin
      bad++; $display("FAIL b2b_first: got %0d %0d %0d, want %0d %0d %0d", (vq.size() > 0) ? vq[0].e : -1, (vq.size() > 0) ? vq[0].p : -1, (vq.size() > 0) ? vq[0].l : -1, mag(d1[0], d1[1]), mag(d1[2], d1[3]), mag(d1[4], d1[5]));
    end
    total++;
    if (vq.size() < 2 || vq[1].e != mag(d2[0], d2[1]) || vq[1].p != mag(d2[2], d2[3]) || vq[1].l != mag(d2[4], d2[5])) begin
      bad++; $display("FAIL b2b_second: got %0d %0d %0d, want %0d %0d %0d", i2q2_early, i2q2_prompt, i2q2_late, mag(d2[0], d2[1]), mag(d2[2], d2[3]), mag(d2[4], d2[5]));
    end
    total++;
    if (oq.size() != 0) begin
      bad++; $display("FAIL b2b_overrun: got %0d overrun pulses, want 0", oq.size());
    end
    $display("txn back_to_back: pulses=%0d second early=%0d prompt=%0d late=%0d", vq.size(), i2q2_early, i2q2_prompt, i2q2_late);
  endtask

  task automatic test_random();
    int d[6];
    int c0;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 6; k++) d[k] = rnd_val();
      vq.delete(); oq.delete();
      start(d, c0);
      for (int k = 2; k <= VC; k++) @(negedge clk);
      #1;
      total++;
      if (vq.size() != 1 || vq[0].c - c0 != VC || oq.size() != 0 ||
          vq[0].e != mag(d[0], d[1]) || vq[0].p != mag(d[2], d[3]) || vq[0].l != mag(d[4], d[5])) begin
        bad++;
        $display("FAIL random_%0d: pulses %0d got %0d %0d %0d, want %0d %0d %0d", n, vq.size(), i2q2_early, i2q2_prompt, i2q2_late, mag(d[0], d[1]), mag(d[2], d[3]), mag(d[4], d[5]));
      end
      $display("txn random_%0d: in=%0d,%0d,%0d,%0d,%0d,%0d out=%0d/%0d/%0d", n, d[0], d[1], d[2], d[3], d[4], d[5], i2q2_early, i2q2_prompt, i2q2_late);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extreme();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
